// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects used by
// both the EX operand muxes and the ID branch-compare muxes.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave):
// stage register/destination info in, enables, flushes and forward selects out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] id_rs, id_rt;
  logic              id_use_rs, id_use_rt;
  logic              id_is_branch, id_redirect, id_rd_hilo, id_md_start;

  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst;
  logic              ex_regwre, ex_memrd;
  logic [REG_AW-1:0] mem_dst;
  logic              mem_regwre, mem_memrd;
  logic [REG_AW-1:0] wb_dst;
  logic              wb_regwre;

  logic              pc_en, ifid_en, ifid_flush, idex_flush;
  fwd_sel_t          fwd_a, fwd_b, id_fwd_a, id_fwd_b;
  logic              md_busy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_redirect,
           id_rd_hilo, id_md_start, ex_rs, ex_rt, ex_dst, ex_regwre, ex_memrd,
           mem_dst, mem_regwre, mem_memrd, wb_dst, wb_regwre,
    input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b,
           id_fwd_a, id_fwd_b, md_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_redirect,
           id_rd_hilo, id_md_start, ex_rs, ex_rt, ex_dst, ex_regwre, ex_memrd,
           mem_dst, mem_regwre, mem_memrd, wb_dst, wb_regwre,
    output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b,
           id_fwd_a, id_fwd_b, md_busy, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/md_busy_timer.sv
// Countdown covering the multi-cycle mult/div unit; busy while nonzero.
module md_busy_timer #(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy
);

  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] r_mdCnt;

  // A start while an operation is still running is ignored; the stall logic
  // keeps such an instruction in ID until the unit is free.
  always_ff @(posedge clk) begin
    if (rst)
      r_mdCnt <= '0;
    else if (i_start && r_mdCnt == '0)
      r_mdCnt <= LOAD_VAL;
    else if (r_mdCnt != '0)
      r_mdCnt <= r_mdCnt - ONE;
  end

  assign o_busy = (r_mdCnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: load-use / branch / mult-div stalls,
// redirect flushes, EX and ID forwarding selects and stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_mdBusyRaw, w_mdBusy, w_mdStart;
  logic w_loadUse, w_branchStall, w_mdStall, w_stall, w_redirFlush;
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

  function automatic logic match(input logic useS, input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst, input logic we);
    return useS && (src != '0) && (dst == src) && we;
  endfunction

  // MEM wins over WB because it is younger, but a load in MEM has no data yet.
  function automatic fwd_sel_t fwdSel(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] memDst,
                                      input logic memWe, input logic memRd,
                                      input logic [REG_AW-1:0] wbDst,
                                      input logic wbWe);
    if (match(1'b1, src, memDst, memWe) && !memRd) return FWD_MEM;
    if (match(1'b1, src, wbDst, wbWe))             return FWD_WB;
    return FWD_REG;
  endfunction

  md_busy_timer #(.MD_LAT(MD_LAT)) u_mdTimer (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mdStart),
    .o_busy  (w_mdBusyRaw)
  );

  assign w_mdBusy  = w_mdBusyRaw && !rst;
  assign w_mdStart = hz.id_md_start && !w_stall;

  assign w_loadUse = hz.ex_memrd &&
    (match(hz.id_use_rs, hz.id_rs, hz.ex_dst, hz.ex_regwre) ||
     match(hz.id_use_rt, hz.id_rt, hz.ex_dst, hz.ex_regwre));

  assign w_branchStall = hz.id_is_branch &&
    (match(hz.id_use_rs, hz.id_rs, hz.ex_dst, hz.ex_regwre) ||
     match(hz.id_use_rt, hz.id_rt, hz.ex_dst, hz.ex_regwre) ||
     (hz.mem_memrd &&
      (match(hz.id_use_rs, hz.id_rs, hz.mem_dst, hz.mem_regwre) ||
       match(hz.id_use_rt, hz.id_rt, hz.mem_dst, hz.mem_regwre))));

  assign w_mdStall    = w_mdBusy && (hz.id_rd_hilo || hz.id_md_start);
  assign w_stall      = w_loadUse || w_branchStall || w_mdStall;
  assign w_redirFlush = hz.id_redirect && !w_stall;

  assign hz.pc_en      = !rst && !w_stall;
  assign hz.ifid_en    = !rst && !w_stall;
  assign hz.ifid_flush = rst || w_redirFlush;
  assign hz.idex_flush = rst || w_stall;
  assign hz.md_busy    = w_mdBusy;

  assign hz.fwd_a    = rst ? FWD_REG : fwdSel(hz.ex_rs, hz.mem_dst, hz.mem_regwre,
                                              hz.mem_memrd, hz.wb_dst, hz.wb_regwre);
  assign hz.fwd_b    = rst ? FWD_REG : fwdSel(hz.ex_rt, hz.mem_dst, hz.mem_regwre,
                                              hz.mem_memrd, hz.wb_dst, hz.wb_regwre);
  assign hz.id_fwd_a = rst ? FWD_REG : fwdSel(hz.id_rs, hz.mem_dst, hz.mem_regwre,
                                              hz.mem_memrd, hz.wb_dst, hz.wb_regwre);
  assign hz.id_fwd_b = rst ? FWD_REG : fwdSel(hz.id_rt, hz.mem_dst, hz.mem_regwre,
                                              hz.mem_memrd, hz.wb_dst, hz.wb_regwre);

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && r_stallCnt != '1)
        r_stallCnt <= r_stallCnt + CNT_ONE;
      if (w_redirFlush && r_flushCnt != '1)
        r_flushCnt <= r_flushCnt + CNT_ONE;
    end
  end

  assign hz.stall_cnt = r_stallCnt;
  assign hz.flush_cnt = r_flushCnt;

endmodule
